// File: rtl/freq_trim_sar_if.sv
// Calibration/control bus between the power-up sequencer and the oscillator trim engine.
interface freq_trim_sar_if #(
    parameter int unsigned TW = 16,
    parameter int unsigned CW = 16,
    parameter int unsigned SW = 8
);
    localparam int unsigned BW = (TW > 1) ? $clog2(TW) : 1;

    logic          start;
    logic          abort;
    logic          mode;
    logic [BW-1:0] msb;
    logic [CW-1:0] rdiv;
    logic [CW-1:0] odiv;
    logic [CW-1:0] tol;
    logic [SW-1:0] settle;
    logic [TW-1:0] trim;
    logic [CW-1:0] meas;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, abort, mode, msb, rdiv, odiv, tol, settle,
        input  trim, meas, busy, done, err
    );

    modport slave (
        input  start, abort, mode, msb, rdiv, odiv, tol, settle,
        output trim, meas, busy, done, err
    );
endinterface

// File: rtl/freq_trim_sar.sv
// Successive-approximation oscillator trim against rclk, with verify window and optional
// closed-loop tracking. Everything runs in the rclk domain; otog is synchronised here.
module freq_trim_sar #(
    parameter int unsigned TW = 16,
    parameter int unsigned CW = 16,
    parameter int unsigned SW = 8
) (
    input  logic            rclk,
    input  logic            rstb,
    input  logic            otog,
    freq_trim_sar_if.slave  bus
);
    localparam int unsigned   BW     = (TW > 1) ? $clog2(TW) : 1;
    localparam logic [BW-1:0] BP_MAX = BW'(TW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_MEAS, S_DECIDE, S_VERIFY, S_TRACK, S_DONE
    } state_t;

    typedef enum logic [1:0] {P_SAR, P_VER, P_TRK} phase_t;

    state_t        state, state_n;
    phase_t        phase, phase_n;
    logic [BW-1:0] bp, bp_n, bp0, bp0_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [CW-1:0] wcnt, wcnt_n, ecnt, ecnt_n, meas, meas_n;
    logic [TW-1:0] trim, trim_n;
    logic          busy, busy_n, done, done_n, err, err_n;
    logic          start_q;
    logic          otog_s1, otog_s2, otog_s3;

    logic          start_rise_c, edge_c, slow_c, out_tol_c;
    logic [CW:0]   diff_c;
    logic [TW-1:0] lim_c;
    logic [BW-1:0] bp_start_c;

    // msb can only exceed TW-1 when TW is not a power of two
    if (TW == (1 << BW)) begin : g_pow2
        assign bp_start_c = bus.msb;
    end else begin : g_clamp
        assign bp_start_c = (bus.msb > BP_MAX) ? BP_MAX : bus.msb;
    end

    assign start_rise_c = bus.start & ~start_q;
    assign edge_c       = otog_s2 ^ otog_s3;
    assign slow_c       = meas < bus.odiv;
    assign diff_c       = (meas >= bus.odiv) ? ({1'b0, meas} - {1'b0, bus.odiv})
                                             : ({1'b0, bus.odiv} - {1'b0, meas});
    assign out_tol_c    = diff_c > {1'b0, bus.tol};
    // tracking ceiling: all ones in bits [bp0:0]
    assign lim_c        = {TW{1'b1}} >> (BP_MAX - bp0);

    assign bus.trim = trim;
    assign bus.meas = meas;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.err  = err;

    // Two-flop synchroniser plus a delay flop for edge detection
    always_ff @(posedge rclk or negedge rstb) begin
        if (!rstb) begin
            otog_s1 <= 1'b0;
            otog_s2 <= 1'b0;
            otog_s3 <= 1'b0;
        end else begin
            otog_s1 <= otog;
            otog_s2 <= otog_s1;
            otog_s3 <= otog_s2;
        end
    end

    always_ff @(posedge rclk or negedge rstb) begin
        if (!rstb) begin
            state   <= S_IDLE;
            phase   <= P_SAR;
            bp      <= '0;
            bp0     <= '0;
            scnt    <= '0;
            wcnt    <= '0;
            ecnt    <= '0;
            meas    <= '0;
            trim    <= TW'(1) << (TW - 1);
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bp      <= bp_n;
            bp0     <= bp0_n;
            scnt    <= scnt_n;
            wcnt    <= wcnt_n;
            ecnt    <= ecnt_n;
            meas    <= meas_n;
            trim    <= trim_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
            start_q <= bus.start;
        end
    end

    // Counters are loaded on entry to SETTLE/MEAS, so config is sampled there
    always_comb begin
        state_n = state;
        phase_n = phase;
        bp_n    = bp;
        bp0_n   = bp0;
        scnt_n  = scnt;
        wcnt_n  = wcnt;
        ecnt_n  = ecnt;
        meas_n  = meas;
        trim_n  = trim;
        busy_n  = busy;
        done_n  = done;
        err_n   = err;

        if (bus.abort) begin
            state_n = S_IDLE;
            phase_n = P_SAR;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_rise_c) begin
                        bp_n    = bp_start_c;
                        bp0_n   = bp_start_c;
                        trim_n  = TW'(1) << bp_start_c;
                        done_n  = 1'b0;
                        err_n   = 1'b0;
                        busy_n  = 1'b1;
                        phase_n = P_SAR;
                        scnt_n  = bus.settle;
                        state_n = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (scnt == '0) begin
                        wcnt_n  = bus.rdiv;
                        ecnt_n  = '0;
                        state_n = S_MEAS;
                    end else begin
                        scnt_n = scnt - SW'(1);
                    end
                end
                S_MEAS: begin
                    if (wcnt != '0) begin
                        wcnt_n = wcnt - CW'(1);
                        if (edge_c && (ecnt != {CW{1'b1}})) ecnt_n = ecnt + CW'(1);
                    end else begin
                        meas_n = ecnt;
                        case (phase)
                            P_SAR:   state_n = S_DECIDE;
                            P_VER:   state_n = S_VERIFY;
                            default: state_n = S_TRACK;
                        endcase
                    end
                end
                S_DECIDE: begin
                    trim_n[bp] = slow_c;
                    if (bp != '0) begin
                        trim_n[bp - BW'(1)] = 1'b1;
                        bp_n = bp - BW'(1);
                    end else begin
                        phase_n = P_VER;
                    end
                    scnt_n  = bus.settle;
                    state_n = S_SETTLE;
                end
                S_VERIFY: begin
                    err_n  = out_tol_c;
                    done_n = 1'b1;
                    if (bus.mode) begin
                        phase_n = P_TRK;
                        state_n = S_TRACK;
                    end else begin
                        busy_n  = 1'b0;
                        state_n = S_DONE;
                    end
                end
                S_TRACK: begin
                    if (!out_tol_c) begin
                        err_n = 1'b0;
                    end else begin
                        err_n = 1'b1;
                        if (slow_c) begin
                            if (trim < lim_c) trim_n = trim + TW'(1);
                        end else if (trim != '0) begin
                            trim_n = trim - TW'(1);
                        end
                    end
                    phase_n = P_TRK;
                    scnt_n  = bus.settle;
                    state_n = S_SETTLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end
endmodule
